burst_rr_sched: RTL and testbench

- Burst-oriented round-robin scheduler that shares the single destination FIFO among N_SRC source FIFOs in the router.
- It owns the pop/push sequencing: it grants one source at a time and moves up to BURST words from that source to the destination, then re-arbitrates.
- It replaces the per-word req/gnt pairing, so that short bursts from one source are not interleaved word-by-word with another's.
- It also provides a free-running cycle counter and a transfer counter for debug and performance monitoring.

---
 rtl/burst_rr_sched.sv | 147 ++++++++++++++
 tb/tb_burst_rr_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_rr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : burst_rr_sched                                                |
// | Purpose  : Burst round-robin mover from N_SRC show-ahead FIFOs into one  |
// |            destination FIFO, with cycle and transfer counters.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module burst_rr_sched #(
  parameter int N_SRC = 2,
  parameter int WIDTH = 64,
  parameter int BURST = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic [N_SRC-1:0]       src_empty_i,
  input  logic [N_SRC*WIDTH-1:0] src_data_i,
  output logic [N_SRC-1:0]       src_pop_o,
  input  logic                   dst_full_i,
  output logic                   dst_push_o,
  output logic [WIDTH-1:0]       dst_data_o,
  output logic [N_SRC-1:0]       gnt_o,
  output logic                   busy_o,
  output logic [31:0]            cycle_o,
  output logic [31:0]            xfer_cnt_o
);

  localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BCNT_W = $clog2(BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_SRC-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [31:0]         cycle_q;
  logic [31:0]         xfer_q;

  logic                any_req;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    owner_next;
  logic                owner_empty;
  logic                xfer_ok;
  int                  idx;

  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    any_req = 1'b0;
    sel     = ptr_q;
    idx     = 0;
    for (int off = N_SRC - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_SRC) begin
        idx = idx - N_SRC;
      end
      if (!src_empty_i[idx]) begin
        sel     = IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign owner_next  = (int'(owner_q) == N_SRC - 1) ? '0 : owner_q + 1'b1;
  assign owner_empty = src_empty_i[owner_q];
  assign xfer_ok     = reset_i && (state_q == ST_XFER) && !owner_empty && !dst_full_i;

  always_comb begin
    src_pop_o = '0;
    if (xfer_ok) begin
      src_pop_o[owner_q] = 1'b1;
    end
  end

  assign dst_push_o = xfer_ok;
  assign dst_data_o = src_data_i[int'(owner_q)*WIDTH +: WIDTH];
  assign gnt_o      = gnt_q;
  assign busy_o     = (state_q == ST_XFER);
  assign cycle_o    = cycle_q;
  assign xfer_cnt_o = xfer_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i && any_req) begin
          state_d    = ST_XFER;
          owner_d    = sel;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          bcnt_d     = '0;
        end
      end
      ST_XFER: begin
        // An empty owner releases even when the destination is also full.
        if (owner_empty) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = owner_next;
        end else if (!dst_full_i) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(BURST - 1)) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            ptr_d   = owner_next;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      cycle_q <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      cycle_q <= cycle_q + 32'd1;
      if (xfer_ok) begin
        xfer_q <= xfer_q + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_rr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_burst_rr_sched                                             |
// | Purpose  : Directed self-checking bench for burst_rr_sched (2 src, B=4). |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_burst_rr_sched;

  localparam int N_SRC = 2;
  localparam int WIDTH = 64;
  localparam int BURST = 4;

  logic                   clk;
  logic                   reset_n;
  logic                   en;
  logic [N_SRC-1:0]       src_empty;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_pop;
  logic                   dst_full;
  logic                   dst_push;
  logic [WIDTH-1:0]       dst_data;
  logic [N_SRC-1:0]       gnt;
  logic                   busy;
  logic [31:0]            cycle;
  logic [31:0]            xfer_cnt;

  burst_rr_sched #(.N_SRC(N_SRC), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk_i       (clk),
    .reset_i     (reset_n),
    .en_i        (en),
    .src_empty_i (src_empty),
    .src_data_i  (src_data),
    .src_pop_o   (src_pop),
    .dst_full_i  (dst_full),
    .dst_push_o  (dst_push),
    .dst_data_o  (dst_data),
    .gnt_o       (gnt),
    .busy_o      (busy),
    .cycle_o     (cycle),
    .xfer_cnt_o  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] push_log[$];
  logic [31:0] cyc_log[$];
  logic [1:0]  gnt_log[$];
  logic [63:0] exp_q[$];

  logic [1:0]  obs_pop;
  logic        obs_push;
  logic [63:0] obs_data;
  logic [1:0]  obs_gnt;
  logic        obs_busy;
  logic [31:0] obs_cycle;
  logic [31:0] obs_xfer;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs();
    src_empty[0] = (q0.size() == 0);
    src_empty[1] = (q1.size() == 0);
    src_data     = '0;
    if (q0.size() != 0) src_data[63:0]   = q0[0];
    if (q1.size() != 0) src_data[127:64] = q1[0];
  endtask

  // Observe at the falling edge, retire popped words, re-drive heads after the rising edge.
  task automatic tick();
    @(negedge clk);
    obs_pop   = src_pop;
    obs_push  = dst_push;
    obs_data  = dst_data;
    obs_gnt   = gnt;
    obs_busy  = busy;
    obs_cycle = cycle;
    obs_xfer  = xfer_cnt;
    if (obs_push) begin
      push_log.push_back(obs_data);
      cyc_log.push_back(obs_cycle);
      gnt_log.push_back(obs_gnt);
    end
    if (obs_pop[0] && q0.size() != 0) void'(q0.pop_front());
    if (obs_pop[1] && q1.size() != 0) void'(q1.pop_front());
    @(posedge clk);
    #1;
    drive_srcs();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 64'(push_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < push_log.size()) check($sformatf("%s_w%0d", tag, i), push_log[i], exp_q[i]);
    end
  endtask

  task automatic clear_logs();
    push_log.delete();
    cyc_log.delete();
    gnt_log.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    en       = 1'b1;
    dst_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(64'h100 + 64'(i));
      q1.push_back(64'h200 + 64'(i));
    end
    drive_srcs();

    // Reset held for three cycles with both sources non-empty
    for (int i = 0; i < 3; i++) tick();
    check("rst_gnt",   64'(obs_gnt),   64'h0);
    check("rst_pop",   64'(obs_pop),   64'h0);
    check("rst_push",  64'(obs_push),  64'h0);
    check("rst_cycle", 64'(obs_cycle), 64'h0);
    check("rst_busy",  64'(obs_busy),  64'h0);
    reset_n = 1'b1;

    // Alternating bursts
    tick();
    check("rel_cycle0", 64'(obs_cycle), 64'h0);
    tick();
    check("rel_cycle1", 64'(obs_cycle), 64'h1);
    check("first_gnt",  64'(obs_gnt),   64'h1);
    check("first_data", obs_data,       64'h100);
    tick();
    check("rel_cycle2", 64'(obs_cycle), 64'h2);
    for (int i = 0; i < 18; i++) tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h100 + 64'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h200 + 64'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(64'h100 + 64'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(64'h200 + 64'(i));
    check_log("alt");
    if (cyc_log.size() >= 5) check("alt_gap", 64'(cyc_log[4] - cyc_log[3]), 64'd2);
    check("alt_xfer", 64'(obs_xfer), 64'd16);
    check("alt_idle", 64'(obs_gnt),  64'h0);

    // Short source: src0 has 2 words, src1 has 5
    clear_logs();
    q0 = '{64'h300, 64'h301};
    for (int i = 0; i < 5; i++) q1.push_back(64'h400 + 64'(i));
    drive_srcs();
    for (int i = 0; i < 14; i++) tick();
    exp_q = '{64'h300, 64'h301, 64'h400, 64'h401, 64'h402, 64'h403, 64'h404};
    check_log("short");
    if (gnt_log.size() == 7) begin
      check("short_gnt0", 64'(gnt_log[0]), 64'h1);
      check("short_gnt2", 64'(gnt_log[2]), 64'h2);
      check("short_gnt6", 64'(gnt_log[6]), 64'h2);
    end
    check("short_ptr",  64'(dut.ptr_q), 64'h0);
    check("short_xfer", 64'(obs_xfer),  64'd23);

    // Backpressure after two words of a burst
    clear_logs();
    for (int i = 0; i < 4; i++) q0.push_back(64'h500 + 64'(i));
    drive_srcs();
    for (int i = 0; i < 3; i++) tick();
    dst_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_quiet", 64'({obs_pop, obs_push}), 64'h0);
      check("bp_gnt",   64'(obs_gnt),             64'h1);
    end
    check("bp_bcnt", 64'(dut.bcnt_q), 64'd2);
    dst_full = 1'b0;
    tick();
    check("bp_resume", obs_data, 64'h502);
    tick();
    tick();
    exp_q = '{64'h500, 64'h501, 64'h502, 64'h503};
    check_log("bp");

    // en dropped during the second word of a burst
    clear_logs();
    for (int i = 0; i < 8; i++) q0.push_back(64'h600 + 64'(i));
    drive_srcs();
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("en_last_word", obs_data, 64'h603);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_hold", 64'({obs_gnt, obs_push}), 64'h0);
    end
    en = 1'b1;
    tick();
    check("en_arb_cycle", 64'({obs_gnt, obs_push}), 64'h0);
    tick();
    check("en_regrant", 64'(obs_gnt), 64'h1);
    check("en_data",    obs_data,     64'h604);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h600 + 64'(i));
    check_log("en");

    // Reset in the middle of a burst
    clear_logs();
    for (int i = 0; i < 8; i++) q1.push_back(64'h700 + 64'(i));
    drive_srcs();
    tick();
    tick();
    check("mr_gnt", 64'(obs_gnt), 64'h2);
    reset_n = 1'b0;
    tick();
    check("mr_asserted", 64'({obs_pop, obs_push}), 64'h0);
    reset_n = 1'b1;
    tick();
    check("mr_gnt0", 64'(obs_gnt),  64'h0);
    check("mr_push", 64'(obs_push), 64'h0);
    check("mr_xfer", 64'(obs_xfer), 64'h0);
    check("mr_left", 64'(q1.size()), 64'd7);

    // Cycle counter wrap
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    tick();
    check("wrap_pre",  64'(obs_cycle), 64'hFFFF_FFFF);
    tick();
    check("wrap_post", 64'(obs_cycle), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
